hart_run_controller: RTL and testbench

- Testbench-side/system-side sequencer that drives the ap_ctrl_hs block-level handshake of the hart core: launches a programmed number of transactions, per transaction waits for ap_ready then ap_done, then inserts a configurable gap.
- Measures per-transaction latency, tracks the maximum, and runs a watchdog.
- Generates the level finish signal consumed by the dataflow/status monitors.

---
 rtl/hart_ctrl_pkg.sv | 15 +
 rtl/hart_lat_counter.sv | 41 ++++
 rtl/hart_run_controller.sv | 147 ++++++++++++++
 tb/tb_hart_run_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hart_ctrl_pkg.sv
// Shared state encoding and default widths for the hart run controller.
package hart_ctrl_pkg;

    localparam int unsigned TXN_W_DEF = 16;
    localparam int unsigned LAT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

endpackage

// File: rtl/hart_lat_counter.sv
// Saturating per-transaction latency counter with running maximum and watchdog compare.
module hart_lat_counter #(
    parameter int unsigned LAT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    input  logic             capture,
    output logic [LAT_W-1:0] count,
    output logic [LAT_W-1:0] max_count,
    output logic             timeout_hit
);

    localparam logic [LAT_W-1:0] LIMIT = LAT_W'(TIMEOUT_CYCLES);

    // load wins over clear so a run start can both wipe history and arm count=1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            max_count <= '0;
        end else begin
            if (load)
                count <= LAT_W'(1);
            else if (clear)
                count <= '0;
            else if (inc && (count != '1))
                count <= count + LAT_W'(1);

            if (clear)
                max_count <= '0;
            else if (capture && (count > max_count))
                max_count <= count;
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count >= LIMIT);

endmodule

// File: rtl/hart_run_controller.sv
// Drives the ap_ctrl_hs handshake for a programmed number of transactions,
// recording latency statistics and watchdog/protocol errors.
module hart_run_controller
    import hart_ctrl_pkg::*;
#(
    parameter int unsigned TXN_W          = TXN_W_DEF,
    parameter int unsigned LAT_W          = LAT_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES     = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [TXN_W-1:0] cfg_num_txn,
    input  logic             abort,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             busy,
    output logic             finish,
    output logic [TXN_W-1:0] txn_done_cnt,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] max_latency,
    output logic             timeout_err,
    output logic             proto_err
);

    state_t           state, state_nxt;
    logic [TXN_W-1:0] num_txn;
    logic [TXN_W-1:0] txn_inc;
    logic [31:0]      gap_cnt;
    logic [LAT_W-1:0] lat_count;
    logic             active, done_evt, timeout_hit;
    logic             accept, cnt_clear, cnt_load, set_timeout, set_proto;

    assign active   = (state == ST_START) || (state == ST_WAIT_DONE);
    assign done_evt = active && ap_done;
    assign txn_inc  = txn_done_cnt + TXN_W'(1);

    hart_lat_counter #(
        .LAT_W          (LAT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_lat (
        .clock       (clock),
        .reset       (reset),
        .clear       (cnt_clear),
        .load        (cnt_load),
        .inc         (active),
        .capture     (done_evt),
        .count       (lat_count),
        .max_count   (max_latency),
        .timeout_hit (timeout_hit)
    );

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        set_timeout = 1'b0;
        set_proto   = 1'b0;
        case (state)
            ST_IDLE, ST_FINISH: begin
                if (cfg_start) begin
                    accept    = 1'b1;
                    cnt_clear = 1'b1;
                    if (cfg_num_txn == '0) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt = ST_START;
                        cnt_load  = 1'b1;
                    end
                end
            end
            ST_START, ST_WAIT_DONE: begin
                // completion outranks abort and watchdog in the same cycle
                if (done_evt) begin
                    set_proto = (state == ST_START) && !ap_ready;
                    if (abort || (txn_inc == num_txn)) begin
                        state_nxt = ST_FINISH;
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt = ST_START;
                        cnt_load  = 1'b1;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end else if (abort) begin
                    state_nxt = ST_FINISH;
                end else if (timeout_hit) begin
                    set_timeout = 1'b1;
                    state_nxt   = ST_FINISH;
                end else if ((state == ST_START) && ap_ready) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_nxt = ST_FINISH;
                end else if (gap_cnt == GAP_CYCLES - 1) begin
                    state_nxt = ST_START;
                    cnt_load  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            num_txn      <= '0;
            txn_done_cnt <= '0;
            last_latency <= '0;
            timeout_err  <= 1'b0;
            proto_err    <= 1'b0;
            gap_cnt      <= '0;
            ap_start     <= 1'b0;
            busy         <= 1'b0;
            finish       <= 1'b0;
        end else begin
            state    <= state_nxt;
            ap_start <= (state_nxt == ST_START);
            busy     <= (state_nxt == ST_START) || (state_nxt == ST_WAIT_DONE) ||
                        (state_nxt == ST_GAP);
            finish   <= (state_nxt == ST_FINISH);
            gap_cnt  <= (state == ST_GAP) ? gap_cnt + 32'd1 : '0;

            if (accept) begin
                num_txn      <= cfg_num_txn;
                txn_done_cnt <= '0;
                last_latency <= '0;
                timeout_err  <= 1'b0;
                proto_err    <= 1'b0;
            end else begin
                if (done_evt) begin
                    txn_done_cnt <= txn_inc;
                    last_latency <= lat_count;
                end
                if (set_timeout)
                    timeout_err <= 1'b1;
                if (set_proto)
                    proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hart_run_controller.sv
// Directed bench for hart_run_controller with a reactive ap_ctrl_hs core model.
module tb_hart_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_start0 = 1'b0, cfg_start1 = 1'b0;
    logic [15:0] cfg_num_txn = '0;
    logic        abort = 1'b0;
    logic        ap_ready = 1'b0, ap_done = 1'b0;

    logic        ap_start0, busy0, finish0, tmo0, proto0;
    logic [15:0] txn0;
    logic [31:0] last0, max0;
    logic        ap_start1, busy1, finish1, tmo1, proto1;
    logic [15:0] txn1;
    logic [31:0] last1, max1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    hart_run_controller #(.TXN_W(16), .LAT_W(32), .TIMEOUT_CYCLES(16), .GAP_CYCLES(0)) u0 (
        .clock(clock), .reset(reset), .cfg_start(cfg_start0), .cfg_num_txn(cfg_num_txn),
        .abort(abort), .ap_start(ap_start0), .ap_ready(ap_ready), .ap_done(ap_done),
        .busy(busy0), .finish(finish0), .txn_done_cnt(txn0), .last_latency(last0),
        .max_latency(max0), .timeout_err(tmo0), .proto_err(proto0));

    hart_run_controller #(.TXN_W(16), .LAT_W(32), .TIMEOUT_CYCLES(0), .GAP_CYCLES(2)) u1 (
        .clock(clock), .reset(reset), .cfg_start(cfg_start1), .cfg_num_txn(cfg_num_txn),
        .abort(1'b0), .ap_start(ap_start1), .ap_ready(ap_ready), .ap_done(ap_done),
        .busy(busy1), .finish(finish1), .txn_done_cnt(txn1), .last_latency(last1),
        .max_latency(max1), .timeout_err(tmo1), .proto_err(proto1));

    // Core model: k is the cycle index within the current transaction (1 = first START cycle).
    bit   mdl_sel;
    int   k, bursts, hi_cur, hi_min, hi_max, lo_cur, lo_last;
    int   rdy_tab [4];
    int   done_tab[4];
    logic st_prev, done_prev;

    always @(negedge clock) begin
        logic st;
        int   idx;
        st = mdl_sel ? ap_start1 : ap_start0;
        if (st && (!st_prev || done_prev)) begin
            if (bursts > 0 && !st_prev) lo_last = lo_cur;
            bursts++;
            k = 1;
        end else if (k != 0) begin
            k++;
        end
        if (st) begin
            if (!st_prev) hi_cur = 1; else hi_cur++;
        end else begin
            if (st_prev) begin
                if (hi_cur < hi_min) hi_min = hi_cur;
                if (hi_cur > hi_max) hi_max = hi_cur;
                lo_cur = 1;
            end else begin
                lo_cur++;
            end
        end
        idx = (bursts > 0) ? bursts - 1 : 0;
        if (idx > 3) idx = 3;
        ap_ready  = (k != 0) && (k == rdy_tab[idx]);
        ap_done   = (k != 0) && (k == done_tab[idx]);
        done_prev = ap_done;
        if (ap_done) k = 0;
        st_prev = st;
    end

    task automatic mdl_reset(input bit sel, input int rdy, input int dn);
        mdl_sel = sel; k = 0; bursts = 0; hi_cur = 0; hi_min = 1000; hi_max = 0;
        lo_cur = 0; lo_last = -1; st_prev = 1'b0; done_prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdy_tab[i]  = rdy;
            done_tab[i] = dn;
        end
    endtask

    task automatic start_run(input bit sel, input int n);
        @(negedge clock); #1;
        cfg_num_txn = 16'(n);
        if (sel) cfg_start1 = 1'b1; else cfg_start0 = 1'b1;
        @(negedge clock); #1;
        cfg_start0 = 1'b0;
        cfg_start1 = 1'b0;
    endtask

    task automatic wait_finish(input bit sel, input int budget, output int cycles);
        cycles = 0;
        while (!(sel ? finish1 : finish0) && cycles < budget) begin
            @(negedge clock); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if ({ap_start0, busy0, finish0, tmo0, proto0, txn0, last0, max0} !== '0) begin
            n_bad++; $display("FAIL reset_u0: got %0b/%0b/%0b/%0b/%0b/%0d/%0d/%0d want all 0",
                ap_start0, busy0, finish0, tmo0, proto0, txn0, last0, max0); end
        n_cmp++; if ({ap_start1, busy1, finish1, tmo1, proto1, txn1, last1, max1} !== '0) begin
            n_bad++; $display("FAIL reset_u1: got %0b/%0b/%0b/%0b/%0b/%0d/%0d/%0d want all 0",
                ap_start1, busy1, finish1, tmo1, proto1, txn1, last1, max1); end
    endtask

    task automatic test_zero_txn;
        logic seen_start;
        mdl_reset(0, 0, 0);
        start_run(0, 0);
        n_cmp++; if (finish0 !== 1'b1) begin n_bad++; $display("FAIL zero_finish: got %0b want 1", finish0); end
        seen_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ap_start0) seen_start = 1'b1;
            @(negedge clock); #1;
        end
        n_cmp++; if (seen_start !== 1'b0) begin n_bad++; $display("FAIL zero_ap_start: got %0b want 0", seen_start); end
        n_cmp++; if (txn0 !== 16'd0) begin n_bad++; $display("FAIL zero_txn: got %0d want 0", txn0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %0b want 0", busy0); end
    endtask

    task automatic test_basic;
        int cyc;
        mdl_reset(0, 2, 5);
        start_run(0, 3);
        wait_finish(0, 200, cyc);
        n_cmp++; if (finish0 !== 1'b1) begin n_bad++; $display("FAIL basic_finish: got %0b want 1 after %0d cycles", finish0, cyc); end
        n_cmp++; if (txn0 !== 16'd3) begin n_bad++; $display("FAIL basic_txn: got %0d want 3", txn0); end
        n_cmp++; if (last0 !== 32'd5) begin n_bad++; $display("FAIL basic_last: got %0d want 5", last0); end
        n_cmp++; if (max0 !== 32'd5) begin n_bad++; $display("FAIL basic_max: got %0d want 5", max0); end
        n_cmp++; if (bursts !== 3) begin n_bad++; $display("FAIL basic_bursts: got %0d want 3", bursts); end
        n_cmp++; if (hi_min !== 2 || hi_max !== 2) begin n_bad++; $display("FAIL basic_burst_len: got %0d..%0d want 2..2", hi_min, hi_max); end
        n_cmp++; if ({busy0, ap_start0, tmo0, proto0} !== 4'b0) begin n_bad++; $display("FAIL basic_idle_flags: got %b want 0000", {busy0, ap_start0, tmo0, proto0}); end
    endtask

    task automatic test_gap;
        int cyc;
        mdl_reset(1, 1, 1);
        start_run(1, 2);
        wait_finish(1, 100, cyc);
        n_cmp++; if (finish1 !== 1'b1) begin n_bad++; $display("FAIL gap_finish: got %0b want 1", finish1); end
        n_cmp++; if (txn1 !== 16'd2) begin n_bad++; $display("FAIL gap_txn: got %0d want 2", txn1); end
        n_cmp++; if (last1 !== 32'd1 || max1 !== 32'd1) begin n_bad++; $display("FAIL gap_latency: got last %0d max %0d want 1 1", last1, max1); end
        n_cmp++; if (lo_last !== 2) begin n_bad++; $display("FAIL gap_low_cycles: got %0d want 2", lo_last); end
        n_cmp++; if (bursts !== 2 || hi_max !== 1) begin n_bad++; $display("FAIL gap_bursts: got %0d bursts max len %0d want 2 1", bursts, hi_max); end
        n_cmp++; if (proto1 !== 1'b0) begin n_bad++; $display("FAIL gap_proto: got %0b want 0", proto1); end
    endtask

    task automatic test_timeout;
        int fire_k;
        mdl_reset(0, 2, 0);
        start_run(0, 1);
        fire_k = -1;
        for (int i = 0; i < 40 && fire_k < 0; i++) begin
            if (tmo0) fire_k = k;
            else begin @(negedge clock); #1; end
        end
        n_cmp++; if (fire_k !== 17) begin n_bad++; $display("FAIL timeout_cycle: got %0d want 17", fire_k); end
        n_cmp++; if ({finish0, busy0, ap_start0} !== 3'b100) begin n_bad++; $display("FAIL timeout_state: got %b want 100", {finish0, busy0, ap_start0}); end
        n_cmp++; if (txn0 !== 16'd0 || last0 !== 32'd0) begin n_bad++; $display("FAIL timeout_counts: got txn %0d last %0d want 0 0", txn0, last0); end
    endtask

    task automatic test_proto;
        int cyc;
        mdl_reset(0, 0, 0);
        rdy_tab[0] = 0; done_tab[0] = 3;
        rdy_tab[1] = 2; done_tab[1] = 2;
        start_run(0, 2);
        wait_finish(0, 100, cyc);
        n_cmp++; if (proto0 !== 1'b1) begin n_bad++; $display("FAIL proto_flag: got %0b want 1", proto0); end
        n_cmp++; if (txn0 !== 16'd2) begin n_bad++; $display("FAIL proto_txn: got %0d want 2", txn0); end
        n_cmp++; if (last0 !== 32'd2 || max0 !== 32'd3) begin n_bad++; $display("FAIL proto_latency: got last %0d max %0d want 2 3", last0, max0); end
        n_cmp++; if (tmo0 !== 1'b0 || finish0 !== 1'b1) begin n_bad++; $display("FAIL proto_end: got tmo %0b finish %0b want 0 1", tmo0, finish0); end
    endtask

    task automatic test_abort;
        mdl_reset(0, 1, 0);
        start_run(0, 3);
        for (int i = 0; i < 10 && k != 3; i++) begin @(negedge clock); #1; end
        abort = 1'b1;
        @(negedge clock); #1;
        abort = 1'b0;
        n_cmp++; if ({finish0, busy0, ap_start0} !== 3'b100) begin n_bad++; $display("FAIL abort_state: got %b want 100", {finish0, busy0, ap_start0}); end
        n_cmp++; if (txn0 !== 16'd0 || last0 !== 32'd0 || tmo0 !== 1'b0) begin n_bad++; $display("FAIL abort_counts: got txn %0d last %0d tmo %0b want 0 0 0", txn0, last0, tmo0); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        mdl_reset(0, 1, 4);
        start_run(0, 4);
        cyc = 0;
        while (!(txn0 == 16'd1 && k == 2) && cyc < 50) begin @(negedge clock); #1; cyc++; end
        n_cmp++; if (busy0 !== 1'b1 || ap_start0 !== 1'b0 || txn0 !== 16'd1) begin n_bad++; $display("FAIL rmid_reach: got busy %0b start %0b txn %0d want 1 0 1", busy0, ap_start0, txn0); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({ap_start0, busy0, finish0, tmo0, proto0, txn0, last0, max0} !== '0) begin
            n_bad++; $display("FAIL rmid_async_clear: got %0b/%0b/%0b/%0d/%0d/%0d want all 0",
                ap_start0, busy0, finish0, txn0, last0, max0); end
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
        n_cmp++; if ({busy0, finish0, ap_start0} !== 3'b000) begin n_bad++; $display("FAIL rmid_idle: got %b want 000", {busy0, finish0, ap_start0}); end
        mdl_reset(0, 1, 2);
        start_run(0, 1);
        wait_finish(0, 50, cyc);
        n_cmp++; if (finish0 !== 1'b1 || txn0 !== 16'd1) begin n_bad++; $display("FAIL rmid_rerun: got finish %0b txn %0d want 1 1", finish0, txn0); end
        n_cmp++; if (last0 !== 32'd2 || max0 !== 32'd2) begin n_bad++; $display("FAIL rmid_latency: got last %0d max %0d want 2 2", last0, max0); end
    endtask

    initial begin
        mdl_reset(0, 0, 0);
        #1;
        test_reset;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        test_zero_txn;
        test_basic;
        test_gap;
        test_timeout;
        test_proto;
        test_abort;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no end of run want completion");
        $fatal(1);
    end

endmodule
